// File: rtl/sram_pkg.sv
// Shared types for the banked SRAM: fill FSM encoding and bank-count derivation.
// Pure declarations; no timing or flow control of its own.
package sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_t;

   function automatic int num_banks(input int addr_w, input int bank_addr_w);
      return 1 << (addr_w - bank_addr_w);
   endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port synchronous RAM bank, 2^BANK_ADDR_W x DATA_W; write and read both take effect on the clock edge.
// Read data is registered (one-cycle latency) and holds while re is low; no backpressure.
module sram_bank #(
   parameter int BANK_ADDR_W = 15,
   parameter int DATA_W      = 8
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic                   re,
   input  logic [BANK_ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0]      din,
   output logic [DATA_W-1:0]      dout
);

   logic [DATA_W-1:0] mem [0:(1 << BANK_ADDR_W)-1];

   // Array contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= din;
      if (re)
         dout <= mem[addr];
   end

endmodule

// File: rtl/sram_banked.sv
// Banked SRAM with a host port and a range-fill engine; reads return two edges after acceptance (bank then output register).
// The host is stalled (ready low) while the fill engine owns the memory; accesses are never queued.
module sram_banked
   import sram_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int BANK_ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs,
   input  logic              we,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] datain,
   output logic [DATA_W-1:0] dataout,
   output logic              dout_valid,
   output logic              ready,
   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_value,
   input  logic [ADDR_W-1:0] fill_lo,
   input  logic [ADDR_W-1:0] fill_hi,
   output logic              fill_busy,
   output logic              fill_done
);

   localparam int NB    = num_banks(ADDR_W, BANK_ADDR_W);
   localparam int SEL_W = ADDR_W - BANK_ADDR_W;

   fill_state_t       state;
   logic [ADDR_W:0]   ptr;
   logic [ADDR_W:0]   hi;
   logic [DATA_W-1:0] val;

   logic              host_wr;
   logic              host_rd;
   logic              fill_wr;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [SEL_W-1:0]  mem_sel;
   logic [DATA_W-1:0] bank_q [NB];
   logic [SEL_W-1:0]  sel_q;
   logic              rd_q;

   assign ready    = ~fill_busy;
   assign host_wr  = cs & ready & we;
   assign host_rd  = cs & ready & ~we;
   assign fill_wr  = (state == ST_FILL);
   assign mem_we   = host_wr | fill_wr;
   assign mem_addr = fill_wr ? ptr[ADDR_W-1:0] : address;
   assign mem_din  = fill_wr ? val : datain;
   assign mem_sel  = mem_addr[ADDR_W-1:BANK_ADDR_W];

   for (genvar b = 0; b < NB; b++) begin : g_bank
      sram_bank #(
         .BANK_ADDR_W(BANK_ADDR_W),
         .DATA_W     (DATA_W)
      ) u_bank (
         .clk (clk),
         .we  (mem_we  && (mem_sel == SEL_W'(b))),
         .re  (host_rd && (mem_sel == SEL_W'(b))),
         .addr(mem_addr[BANK_ADDR_W-1:0]),
         .din (mem_din),
         .dout(bank_q[b])
      );
   end

   // Bank select travels with the read so the output mux ignores later address changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q       <= 1'b0;
         sel_q      <= '0;
         dout_valid <= 1'b0;
         dataout    <= '0;
      end else begin
         rd_q       <= host_rd;
         dout_valid <= rd_q;
         if (host_rd)
            sel_q <= address[ADDR_W-1:BANK_ADDR_W];
         if (rd_q)
            dataout <= bank_q[sel_q];
      end
   end

   // The pointer is compared before incrementing, so a fill ending at the top address never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         hi        <= '0;
         val       <= '0;
         fill_busy <= 1'b0;
         fill_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fill_start) begin
                  ptr       <= {1'b0, fill_lo};
                  hi        <= {1'b0, fill_hi};
                  val       <= fill_value;
                  fill_busy <= 1'b1;
                  if (fill_lo <= fill_hi) begin
                     state     <= ST_FILL;
                     fill_done <= 1'b0;
                  end else begin
                     state     <= ST_DONE;
                     fill_done <= 1'b1;
                  end
               end
            end
            ST_FILL: begin
               if (ptr == hi) begin
                  state     <= ST_DONE;
                  fill_done <= 1'b1;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               fill_busy <= 1'b0;
               fill_done <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               fill_busy <= 1'b0;
               fill_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sram_banked.md
SRAM_BANKED -- requirements
Module: sram_banked

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: host address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8: data word width in bits.
REQ-003 SHALL have parameter BANK_ADDR_W, default 15: address width of one bank. NUM_BANKS = 2^(ADDR_W-BANK_ADDR_W), and ADDR_W > BANK_ADDR_W.
REQ-004 Ports:
 clk  in  1  sole clock, all logic on rising edge.
 rst_n  in  1  asynchronous active-low reset.
 cs  in  1  host access request.
 we  in  1  1 = write, 0 = read. Qualified by cs.
 address  in  ADDR_W  host word address. The upper ADDR_W-BANK_ADDR_W bits select the bank.
 datain  in  DATA_W  host write data.
 dataout  out  DATA_W  registered read data.
 dout_valid  out  1  one-cycle pulse marking dataout as new.
 ready  out  1  host access is accepted this cycle.
 fill_start  in  1  one-cycle request to start a fill.
 fill_value  in  DATA_W  word written by the fill.
 fill_lo  in  ADDR_W  first fill address, inclusive.
 fill_hi  in  ADDR_W  last fill address, inclusive.
 fill_busy  out  1  high while the fill engine owns the memory.
 fill_done  out  1  one-cycle pulse when a fill completes.

Function
REQ-005 Host accept: a host access SHALL be accepted on a rising edge where cs=1 and ready=1. When ready=0, cs SHALL be ignored. Host accesses are never queued.
REQ-006 Write: an accepted write SHALL store datain at address on the same edge, in exactly one bank. dout_valid SHALL NOT pulse for a write.
REQ-007 Read: an accepted read at edge N SHALL present the word on dataout with dout_valid=1 after edge N+1 (one-cycle latency).
REQ-008 Bank mux: the bank select SHALL be registered alongside the read, so the dataout mux uses the select of the accepted read and not the current address.
REQ-009 dataout SHALL hold its last value when dout_valid=0.
REQ-010 ready SHALL equal the negation of fill_busy.
REQ-011 Fill FSM states: IDLE, FILL, DONE.
 IDLE -> FILL on fill_start when fill_lo <= fill_hi. This edge latches fill_lo, fill_hi and fill_value.
 IDLE -> DONE on fill_start when fill_lo > fill_hi. No writes occur.
 FILL writes fill_value at the current pointer, one word per cycle, then increments the pointer.
 FILL -> DONE after writing fill_hi.
 DONE -> IDLE unconditionally after one cycle.
REQ-012 A fill of K words SHALL take exactly K cycles in FILL. fill_busy SHALL be high in FILL and DONE. fill_done SHALL be high only in DONE.
REQ-013 When fill_hi equals 2^ADDR_W-1, the pointer SHALL NOT wrap and address 0 SHALL NOT be rewritten. The pointer is ADDR_W+1 bits wide, or the compare is made before the increment.
REQ-014 fill_start SHALL be ignored in FILL and DONE.
REQ-015 Simultaneous cs and fill_start in IDLE: the host access SHALL be accepted on that edge, and the first fill write SHALL occur on the next edge.
REQ-016 A read accepted on the edge that enters FILL SHALL still deliver dout_valid one cycle later.
REQ-017 Memory writes SHALL NOT cross banks. The lower BANK_ADDR_W address bits index within the selected bank.

Reset
REQ-018 While rst_n=0, the block SHALL hold: dataout=0, dout_valid=0, fill_busy=0, fill_done=0, ready=1, FSM=IDLE, and the registered bank select at 0.
REQ-019 Reset during FILL SHALL abort the fill immediately and issue no further writes. Words already written are retained. fill_done SHALL NOT pulse.
REQ-020 Memory array contents SHALL NOT be reset.

Structure
REQ-021 Fill FSM state encoding and the NUM_BANKS derivation SHALL live in the shared package sram_pkg.
REQ-022 Each bank SHALL be one instance of the sub-module sram_bank, a single-port synchronous RAM of 2^BANK_ADDR_W x DATA_W with a per-bank write enable. Banks are instantiated with a generate loop.

Verification
REQ-023 Write then read: write 0xA5 to 0x0001 and 0x5A to 0x8001, then read both -> 0xA5 then 0x5A, each one cycle after its read, with dout_valid pulsing.
REQ-024 Back-to-back reads alternating between banks 0x7FFF and 0x8000 -> each dataout matches its own bank, with no cross-bank mux glitch.
REQ-025 Fill 0x0010..0x0013 with 0xEE -> fill_busy high for 5 cycles (4 FILL + 1 DONE), fill_done pulses once, the four locations read 0xEE, and 0x000F and 0x0014 are unchanged.
REQ-026 Fill with fill_lo=0x0020 and fill_hi=0x001F -> no writes, fill_done on the next cycle, fill_busy high for 1 cycle.
REQ-027 Fill 0xFFFE..0xFFFF -> exactly 2 writes, and address 0x0000 is unchanged.
REQ-028 Assert rst_n=0 two cycles into a 16-word fill -> outputs return to reset values, only the first 2 words are written, and there is no fill_done.
